// File: rtl/avst_capture_packetizer.sv
// ---------------------------------------------------------------------------
// avst_capture_packetizer
//
// Purpose:
//   Consumes the free-running beat stream leaving the timing-adapter FIFO.
//   While idle, every beat is drained and counted as dropped so the FIFO never
//   holds stale samples. A software arm frames the next pkt_len accepted beats
//   into a single Avalon-ST packet. Each beat leaves as {beat_idx[3:0], data}
//   through a one-deep output register that runs at full throughput.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   arm, pkt_len        capture request; pkt_len sampled on an accepted arm
//   in_valid, in_data   upstream beat
//   in_ready            upstream ready (combinational)
//   out_valid, out_data, out_startofpacket, out_endofpacket
//                       registered Avalon-ST source towards the capture sink
//   out_ready           downstream ready
//   busy                capture in progress or an output beat still pending
//   pkt_count           packets delivered downstream (wraps)
//   drop_count          beats discarded while idle (saturates)
// ---------------------------------------------------------------------------
module avst_capture_packetizer #(
   parameter int unsigned DATA_WIDTH = 28,
   parameter int unsigned OUT_WIDTH  = 32,
   parameter int unsigned LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  arm,
   input  logic [LEN_WIDTH-1:0]  pkt_len,
   output logic                  in_ready,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  out_startofpacket,
   output logic                  out_endofpacket,
   output logic                  busy,
   output logic [LEN_WIDTH-1:0]  pkt_count,
   output logic [LEN_WIDTH-1:0]  drop_count
);

   localparam int unsigned IDX_WIDTH = 4;

   // The beat index lives in the top nibble of the output word.
   if (OUT_WIDTH != DATA_WIDTH + IDX_WIDTH) begin : g_width_check
      $error("avst_capture_packetizer: OUT_WIDTH must equal DATA_WIDTH + 4");
   end

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      CAPTURE = 1'b1
   } state_e;

   state_e                 state_q,      state_d;
   logic [LEN_WIDTH-1:0]   cnt_q,        cnt_d;
   logic [LEN_WIDTH-1:0]   len_q,        len_d;
   logic                   out_valid_q,  out_valid_d;
   logic [OUT_WIDTH-1:0]   out_data_q,   out_data_d;
   logic                   sop_q,        sop_d;
   logic                   eop_q,        eop_d;
   logic                   busy_q,       busy_d;
   logic [LEN_WIDTH-1:0]   pkt_count_q,  pkt_count_d;
   logic [LEN_WIDTH-1:0]   drop_count_q, drop_count_d;

   logic                   accept_c;
   logic                   last_beat_c;
   logic                   arm_ok_c;
   logic                   pkt_done_c;

   // Idle always sinks; capture stalls only when the output register is full
   // and the sink is not draining it this cycle.
   assign in_ready    = (state_q == IDLE) || !out_valid_q || out_ready;

   assign accept_c    = (state_q == CAPTURE) && in_valid && in_ready;
   assign last_beat_c = (cnt_q == (len_q - LEN_WIDTH'(1)));
   // An arm is refused while a beat from the previous packet is still pending.
   assign arm_ok_c    = arm && (pkt_len != '0) && !out_valid_q;
   assign pkt_done_c  = out_valid_q && out_ready && eop_q;

   // Next-state and datapath
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      out_valid_d  = out_valid_q && !out_ready;
      out_data_d   = out_data_q;
      sop_d        = sop_q;
      eop_d        = eop_q;
      pkt_count_d  = pkt_count_q;
      drop_count_d = drop_count_q;

      if (pkt_done_c) begin
         pkt_count_d = pkt_count_q + LEN_WIDTH'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (in_valid && (drop_count_q != '1)) begin
               drop_count_d = drop_count_q + LEN_WIDTH'(1);
            end
            if (arm_ok_c) begin
               state_d = CAPTURE;
               len_d   = pkt_len;
               cnt_d   = '0;
            end
         end
         CAPTURE: begin
            if (accept_c) begin
               out_valid_d = 1'b1;
               out_data_d  = OUT_WIDTH'({cnt_q[IDX_WIDTH-1:0], in_data});
               sop_d       = (cnt_q == '0);
               eop_d       = last_beat_c;
               cnt_d       = cnt_q + LEN_WIDTH'(1);
               if (last_beat_c) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Registered so that busy reflects exactly the state and output flops.
      busy_d = (state_d == CAPTURE) || out_valid_d;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         len_q        <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         sop_q        <= 1'b0;
         eop_q        <= 1'b0;
         busy_q       <= 1'b0;
         pkt_count_q  <= '0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         sop_q        <= sop_d;
         eop_q        <= eop_d;
         busy_q       <= busy_d;
         pkt_count_q  <= pkt_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign out_valid         = out_valid_q;
   assign out_data          = out_data_q;
   assign out_startofpacket = sop_q;
   assign out_endofpacket   = eop_q;
   assign busy              = busy_q;
   assign pkt_count         = pkt_count_q;
   assign drop_count        = drop_count_q;

endmodule

// File: tb/tb_avst_capture_packetizer.sv
// ---------------------------------------------------------------------------
// tb_avst_capture_packetizer
//
// Directed bench for avst_capture_packetizer: idle drop counting, basic
// framing, output stall, single-beat and zero-length arms, index wrap with a
// stray arm, and reset in the middle of a packet.
// ---------------------------------------------------------------------------
module tb_avst_capture_packetizer;

   logic        clk;
   logic        reset;
   logic        arm;
   logic [15:0] pkt_len;
   logic        in_ready;
   logic        in_valid;
   logic [27:0] in_data;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_startofpacket;
   logic        out_endofpacket;
   logic        busy;
   logic [15:0] pkt_count;
   logic [15:0] drop_count;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic [31:0] data;
   } beat_t;

   beat_t mon_q[$];

   avst_capture_packetizer #(
      .DATA_WIDTH(28),
      .OUT_WIDTH (32),
      .LEN_WIDTH (16)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .arm              (arm),
      .pkt_len          (pkt_len),
      .in_ready         (in_ready),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .out_ready        (out_ready),
      .out_valid        (out_valid),
      .out_data         (out_data),
      .out_startofpacket(out_startofpacket),
      .out_endofpacket  (out_endofpacket),
      .busy             (busy),
      .pkt_count        (pkt_count),
      .drop_count       (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every beat handed to the sink, sampled mid-cycle.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         mon_q.push_back('{sop: out_startofpacket, eop: out_endofpacket, data: out_data});
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present n consecutive beats, waiting (bounded) on in_ready for each.
   task automatic send_beats(input logic [27:0] base, input int n);
      for (int k = 0; k < n; k++) begin
         int w;
         in_valid = 1'b1;
         in_data  = base + 28'(k);
         w = 0;
         #1;
         while (!in_ready && w < 50) begin
            tick();
            w++;
         end
         if (w == 50) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
         end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      repeat (3) tick();
   endtask

   task automatic arm_pkt(input logic [15:0] len);
      arm     = 1'b1;
      pkt_len = len;
      tick();
      arm     = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      arm = 1'b0; pkt_len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      tests++; if ({out_startofpacket, out_endofpacket} !== 2'b00) begin fails++; $display("FAIL reset_sop_eop: got %b%b want 00", out_startofpacket, out_endofpacket); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (pkt_count !== 16'd0) begin fails++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
      tests++; if (drop_count !== 16'd0) begin fails++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
   endtask

   task automatic test_idle_drop();
      in_valid = 1'b1;
      in_data  = 28'hABCDEF0;
      for (int i = 0; i < 10; i++) begin
         #1;
         tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready: cycle %0d got %b want 1", i, in_ready); end
         tick();
      end
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
      tests++; if (drop_count !== 16'd10) begin fails++; $display("FAIL idle_drop_count: got %0d want 10", drop_count); end
   endtask

   task automatic test_basic();
      logic [31:0] exp_d [4];
      exp_d = '{32'h0000_0100, 32'h1000_0101, 32'h2000_0102, 32'h3000_0103};
      mon_q.delete();
      out_ready = 1'b1;
      arm_pkt(16'd4);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_armed: got %b want 1", busy); end
      send_beats(28'h100, 4);
      drain();
      tests++; if (mon_q.size() !== 4) begin fails++; $display("FAIL basic_beat_count: got %0d want 4", mon_q.size()); end
      if (mon_q.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            tests++; if (mon_q[k].data !== exp_d[k]) begin fails++; $display("FAIL basic_data[%0d]: got %h want %h", k, mon_q[k].data, exp_d[k]); end
            tests++; if (mon_q[k].sop !== (k == 0)) begin fails++; $display("FAIL basic_sop[%0d]: got %b want %b", k, mon_q[k].sop, (k == 0)); end
            tests++; if (mon_q[k].eop !== (k == 3)) begin fails++; $display("FAIL basic_eop[%0d]: got %b want %b", k, mon_q[k].eop, (k == 3)); end
         end
      end
      tests++; if (pkt_count !== 16'd1) begin fails++; $display("FAIL basic_pkt_count: got %0d want 1", pkt_count); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_done: got %b want 0", busy); end
   endtask

   task automatic test_stall();
      logic [31:0] exp_d [4];
      exp_d = '{32'h0000_0200, 32'h1000_0201, 32'h2000_0202, 32'h3000_0203};
      mon_q.delete();
      out_ready = 1'b1;
      arm_pkt(16'd4);
      in_valid = 1'b1; in_data = 28'h200; tick();
      in_data = 28'h201; tick();
      in_data = 28'h202; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
         tick();
         tests++; if (out_valid !== 1'b1 || out_data !== 32'h1000_0201) begin fails++; $display("FAIL stall_hold[%0d]: got v=%b d=%h want v=1 d=10000201", i, out_valid, out_data); end
      end
      out_ready = 1'b1;
      tick();
      in_data = 28'h203; tick();
      drain();
      tests++; if (mon_q.size() !== 4) begin fails++; $display("FAIL stall_beat_count: got %0d want 4", mon_q.size()); end
      if (mon_q.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            tests++; if (mon_q[k].data !== exp_d[k] || mon_q[k].sop !== (k == 0) || mon_q[k].eop !== (k == 3)) begin
               fails++; $display("FAIL stall_beat[%0d]: got %h sop=%b eop=%b want %h", k, mon_q[k].data, mon_q[k].sop, mon_q[k].eop, exp_d[k]);
            end
         end
      end
      tests++; if (pkt_count !== 16'd2) begin fails++; $display("FAIL stall_pkt_count: got %0d want 2", pkt_count); end
   endtask

   task automatic test_short_lengths();
      mon_q.delete();
      out_ready = 1'b1;
      arm_pkt(16'd1);
      send_beats(28'h300, 1);
      drain();
      tests++; if (mon_q.size() !== 1) begin fails++; $display("FAIL len1_beat_count: got %0d want 1", mon_q.size()); end
      if (mon_q.size() == 1) begin
         tests++; if (mon_q[0].data !== 32'h0000_0300 || mon_q[0].sop !== 1'b1 || mon_q[0].eop !== 1'b1) begin
            fails++; $display("FAIL len1_beat: got %h sop=%b eop=%b want 00000300 sop=1 eop=1", mon_q[0].data, mon_q[0].sop, mon_q[0].eop);
         end
      end
      tests++; if (pkt_count !== 16'd3) begin fails++; $display("FAIL len1_pkt_count: got %0d want 3", pkt_count); end
      mon_q.delete();
      arm_pkt(16'd0);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL len0_busy: got %b want 0", busy); end
      in_valid = 1'b1; in_data = 28'h333; tick();
      in_valid = 1'b0; tick();
      tests++; if (out_valid !== 1'b0 || mon_q.size() !== 0) begin fails++; $display("FAIL len0_no_output: got v=%b beats=%0d want v=0 beats=0", out_valid, mon_q.size()); end
      tests++; if (drop_count !== 16'd11) begin fails++; $display("FAIL len0_drop_count: got %0d want 11", drop_count); end
   endtask

   task automatic test_wrap_and_stray_arm();
      mon_q.delete();
      out_ready = 1'b1;
      arm_pkt(16'd20);
      for (int k = 0; k < 20; k++) begin
         arm      = (k == 5);
         pkt_len  = (k == 5) ? 16'd3 : 16'd20;
         in_valid = 1'b1;
         in_data  = 28'h400 + 28'(k);
         tick();
      end
      arm = 1'b0;
      drain();
      tests++; if (mon_q.size() !== 20) begin fails++; $display("FAIL wrap_beat_count: got %0d want 20", mon_q.size()); end
      if (mon_q.size() == 20) begin
         for (int k = 0; k < 20; k++) begin
            logic [31:0] exp;
            exp = {4'(k % 16), 28'h400 + 28'(k)};
            tests++; if (mon_q[k].data !== exp || mon_q[k].sop !== (k == 0) || mon_q[k].eop !== (k == 19)) begin
               fails++; $display("FAIL wrap_beat[%0d]: got %h sop=%b eop=%b want %h", k, mon_q[k].data, mon_q[k].sop, mon_q[k].eop, exp);
            end
         end
      end
      tests++; if (pkt_count !== 16'd4) begin fails++; $display("FAIL wrap_pkt_count: got %0d want 4", pkt_count); end
      tests++; if (drop_count !== 16'd11) begin fails++; $display("FAIL wrap_drop_count: got %0d want 11", drop_count); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wrap_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid_packet();
      int eop_seen;
      mon_q.delete();
      out_ready = 1'b1;
      arm_pkt(16'd6);
      in_valid = 1'b1; in_data = 28'h500; tick();
      in_data = 28'h501; tick();
      in_data = 28'h502; reset = 1'b1; tick();
      reset = 1'b0; in_valid = 1'b0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
      tests++; if (pkt_count !== 16'd0) begin fails++; $display("FAIL rst_mid_pkt_count: got %0d want 0", pkt_count); end
      tick(); tick();
      eop_seen = 0;
      foreach (mon_q[i]) if (mon_q[i].eop) eop_seen++;
      tests++; if (eop_seen !== 0 || out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_no_eop: got eops=%0d v=%b want 0 0", eop_seen, out_valid); end
      mon_q.delete();
      arm_pkt(16'd2);
      send_beats(28'h600, 2);
      drain();
      tests++; if (mon_q.size() !== 2) begin fails++; $display("FAIL rst_fresh_count: got %0d want 2", mon_q.size()); end
      if (mon_q.size() == 2) begin
         tests++; if (mon_q[0].data !== 32'h0000_0600 || mon_q[0].sop !== 1'b1 || mon_q[0].eop !== 1'b0) begin
            fails++; $display("FAIL rst_fresh_first: got %h sop=%b eop=%b want 00000600 sop=1 eop=0", mon_q[0].data, mon_q[0].sop, mon_q[0].eop);
         end
         tests++; if (mon_q[1].data !== 32'h1000_0601 || mon_q[1].sop !== 1'b0 || mon_q[1].eop !== 1'b1) begin
            fails++; $display("FAIL rst_fresh_last: got %h sop=%b eop=%b want 10000601 sop=0 eop=1", mon_q[1].data, mon_q[1].sop, mon_q[1].eop);
         end
      end
      tests++; if (pkt_count !== 16'd1) begin fails++; $display("FAIL rst_fresh_pkt_count: got %0d want 1", pkt_count); end
   endtask

   initial begin
      test_reset();
      test_idle_drop();
      test_basic();
      test_stall();
      test_short_lengths();
      test_wrap_and_stray_arm();
      test_reset_mid_packet();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
